// File: rtl/core_sched.sv
// Job sequencer: steps mem_ctrl through load/transfer/process and deals operand pairs to PUs round-robin.
// Latency: start -> LOAD command next cycle; mc_done in XFER -> earliest pu_start two cycles later.
// Backpressure: holds in DISPATCH (001 held, no pulse) while every PU reports busy; DRAIN waits for all idle.
module core_sched #(
    parameter int NUM_PU = 4,
    parameter int ADDR_W = 6
) (
    input  logic              mc_clk,
    input  logic              mc_reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] job_length,
    input  logic              abort,
    input  logic              mc_done,
    input  logic              mc_data_done,
    input  logic [NUM_PU-1:0] pu_busy,
    output logic [2:0]        mc_data_contition,
    output logic [ADDR_W-1:0] mc_data_length,
    output logic [NUM_PU-1:0] pu_start,
    output logic              busy,
    output logic              job_done,
    output logic              abort_done,
    output logic [ADDR_W:0]   pairs_issued
);

    localparam int RR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

    localparam logic [2:0] C_IDLE = 3'b000;
    localparam logic [2:0] C_LOAD = 3'b100;
    localparam logic [2:0] C_XFER = 3'b010;
    localparam logic [2:0] C_PROC = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_XFER, S_DISPATCH, S_DRAIN, S_FINISH, S_ABORT
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cond_q, cond_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [NUM_PU-1:0]   pu_start_q, pu_start_d;
    logic                busy_q, busy_d;
    logic                job_done_q, job_done_d;
    logic                abort_done_q, abort_done_d;
    logic [ADDR_W:0]     pairs_q, pairs_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [1:0]          astep_q, astep_d;

    logic                grant_vld;
    logic [RR_W-1:0]     grant_idx;
    logic [RR_W:0]       scan_sum;
    logic [RR_W:0]       rr_next_sum;
    logic [ADDR_W:0]     pairs_inc;
    logic [ADDR_W:0]     pairs_target;

    // Rotating priority: first free unit at or above the rr pointer, wrapping modulo NUM_PU.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        for (int i = 0; i < NUM_PU; i++) begin
            scan_sum = {1'b0, rr_q} + (RR_W+1)'(i);
            if (scan_sum >= (RR_W+1)'(NUM_PU)) begin
                scan_sum = scan_sum - (RR_W+1)'(NUM_PU);
            end
            if (!grant_vld && !pu_busy[scan_sum[RR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_sum[RR_W-1:0];
            end
        end
        rr_next_sum = {1'b0, grant_idx} + (RR_W+1)'(1);
        if (rr_next_sum >= (RR_W+1)'(NUM_PU)) begin
            rr_next_sum = '0;
        end
        pairs_inc    = pairs_q + (ADDR_W+1)'(1);
        pairs_target = {1'b0, len_q} + (ADDR_W+1)'(1);
    end

    // Next-state and next-output logic; every output is the registered copy of its _d.
    always_comb begin
        state_d      = state_q;
        cond_d       = cond_q;
        len_d        = len_q;
        pu_start_d   = '0;
        busy_d       = busy_q;
        job_done_d   = 1'b0;
        abort_done_d = 1'b0;
        pairs_d      = pairs_q;
        rr_d         = rr_q;
        astep_d      = astep_q;

        case (state_q)
            S_IDLE: begin
                cond_d = C_IDLE;
                busy_d = 1'b0;
                if (start) begin
                    len_d   = job_length;
                    pairs_d = '0;
                    state_d = S_LOAD;
                    cond_d  = C_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                cond_d = C_LOAD;
                if (mc_done) begin
                    state_d = S_XFER;
                    cond_d  = C_XFER;
                end
            end
            S_XFER: begin
                cond_d = C_XFER;
                // Memory exhausted takes precedence over a pair arriving in the same cycle.
                if (mc_data_done) begin
                    state_d = S_DRAIN;
                    cond_d  = C_PROC;
                end else if (mc_done) begin
                    state_d = S_DISPATCH;
                    cond_d  = C_PROC;
                end
            end
            S_DISPATCH: begin
                cond_d = C_PROC;
                if (grant_vld) begin
                    pu_start_d[grant_idx] = 1'b1;
                    pairs_d = pairs_inc;
                    rr_d    = rr_next_sum[RR_W-1:0];
                    if (pairs_inc == pairs_target) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_XFER;
                        cond_d  = C_XFER;
                    end
                end
            end
            S_DRAIN: begin
                cond_d = C_PROC;
                if (pu_busy == '0) begin
                    state_d    = S_FINISH;
                    cond_d     = C_IDLE;
                    job_done_d = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                cond_d  = C_IDLE;
                busy_d  = 1'b0;
            end
            S_ABORT: begin
                // 010 (already presented on entry), then 001, then 000 walks mem_ctrl back to idle.
                case (astep_q)
                    2'd0: begin
                        cond_d  = C_PROC;
                        astep_d = 2'd1;
                    end
                    2'd1: begin
                        cond_d       = C_IDLE;
                        abort_done_d = 1'b1;
                        astep_d      = 2'd2;
                    end
                    default: begin
                        state_d = S_IDLE;
                        cond_d  = C_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                cond_d  = C_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Cancel overrides everything outside IDLE/ABORT, including a grant being made this cycle.
        if (abort && state_q != S_IDLE && state_q != S_ABORT) begin
            state_d    = S_ABORT;
            cond_d     = C_XFER;
            astep_d    = 2'd0;
            pu_start_d = '0;
            pairs_d    = pairs_q;
            rr_d       = rr_q;
            job_done_d = 1'b0;
            busy_d     = 1'b1;
        end
    end

    // State and output registers, cleared asynchronously alongside mem_ctrl.
    always_ff @(posedge mc_clk or posedge mc_reset) begin
        if (mc_reset) begin
            state_q      <= S_IDLE;
            cond_q       <= C_IDLE;
            len_q        <= '0;
            pu_start_q   <= '0;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            abort_done_q <= 1'b0;
            pairs_q      <= '0;
            rr_q         <= '0;
            astep_q      <= '0;
        end else begin
            state_q      <= state_d;
            cond_q       <= cond_d;
            len_q        <= len_d;
            pu_start_q   <= pu_start_d;
            busy_q       <= busy_d;
            job_done_q   <= job_done_d;
            abort_done_q <= abort_done_d;
            pairs_q      <= pairs_d;
            rr_q         <= rr_d;
            astep_q      <= astep_d;
        end
    end

    assign mc_data_contition = cond_q;
    assign mc_data_length    = len_q;
    assign pu_start          = pu_start_q;
    assign busy              = busy_q;
    assign job_done          = job_done_q;
    assign abort_done        = abort_done_q;
    assign pairs_issued      = pairs_q;

endmodule
